// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exec_pkg
// Brief    : Shared types and constants for the execute-stage multi-cycle
//            unit scheduler.
// Revision : 1.0
// ============================================================================
package exec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } mc_state_e;

    localparam logic MC_DIV = 1'b0;
    localparam logic MC_FPU = 1'b1;

    localparam int          DEF_TIMEOUT_CYCLES = 64;
    localparam logic [31:0] C_ABORT_RESULT     = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/mc_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mc_timeout_ctr
// Brief    : Clearable, saturating cycle counter with an expired flag.
// Revision : 1.0
// ============================================================================
module mc_timeout_ctr
    import exec_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (reset_i || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != W'(LIMIT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    // >= keeps the flag asserted once saturated, so an abort is never missed
    assign o_expired = (r_count >= W'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/exec_mc_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : exec_mc_scheduler
// Brief    : Issues start pulses to the divider/FPU, stalls the pipe while
//            they run, holds the result and drains flushed operations.
// Revision : 1.0
// ============================================================================
module exec_mc_scheduler
    import exec_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             E_valid_i,
    input  logic             E_isDIV_i,
    input  logic             E_isFPU_i,
    input  logic             E_hazard_i,
    input  logic             E_stall_i,
    input  logic             E_flush_i,
    output logic             div_start_o,
    input  logic             div_done_i,
    input  logic [31:0]      div_result_i,
    output logic             fpu_start_o,
    input  logic             fpu_done_i,
    input  logic [31:0]      fpu_result_i,
    output logic             mc_busy_o,
    output logic             mc_resultValid_o,
    output logic [31:0]      mc_result_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] mc_stallCycles_o
);

    mc_state_e   r_state;
    logic        r_sel;
    logic [31:0] r_result;
    logic        r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;

    logic        w_want;
    logic        w_issue;
    logic        w_sel_new;
    logic        w_done;
    logic [31:0] w_unit_result;
    logic        w_expired;
    logic        w_drain_exit;

    assign w_want    = E_valid_i & (E_isDIV_i | E_isFPU_i);
    assign w_issue   = !reset_i & (r_state == IDLE) & w_want & !E_hazard_i & !E_flush_i;
    assign w_sel_new = E_isDIV_i ? MC_DIV : MC_FPU;

    assign div_start_o = w_issue & (w_sel_new == MC_DIV);
    assign fpu_start_o = w_issue & (w_sel_new == MC_FPU);

    // Only the unit latched at issue may complete the operation
    assign w_done        = (r_sel == MC_DIV) ? div_done_i   : fpu_done_i;
    assign w_unit_result = (r_sel == MC_DIV) ? div_result_i : fpu_result_i;
    assign w_drain_exit  = (r_state == DRAIN) & (w_done | w_expired);

    assign mc_busy_o = !reset_i &
                       (w_issue | (r_state == RUN) | ((r_state == DRAIN) & w_want));

    mc_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .i_clr     (w_issue | w_drain_exit),
        .i_en      ((r_state == RUN) | (r_state == DRAIN)),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_sel     <= MC_DIV;
            r_result  <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state <= RUN;
                        r_sel   <= w_sel_new;
                    end
                end
                RUN: begin
                    // Flush wins over a same-cycle done; that result is dropped
                    if (E_flush_i) begin
                        r_state <= DRAIN;
                    end else if (w_done) begin
                        r_state  <= HOLD;
                        r_result <= w_unit_result;
                    end else if (w_expired) begin
                        r_state   <= HOLD;
                        r_result  <= C_ABORT_RESULT;
                        r_timeout <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!E_stall_i || E_flush_i) begin
                        r_state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (w_done) begin
                        r_state <= IDLE;
                    end else if (w_expired) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stall_cnt <= '0;
        end else if (mc_busy_o) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign mc_resultValid_o = (r_state == HOLD);
    assign mc_result_o      = r_result;
    assign timeout_o        = r_timeout;
    assign mc_stallCycles_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_exec_mc_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_mc_scheduler
// Brief    : Randomized self-checking bench; expectations come from a
//            per-operation timeline model of the scheduler.
// Revision : 1.0
// ============================================================================
module tb_exec_mc_scheduler;

    localparam int TO    = 64;
    localparam int CNT_W = 32;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic reset_i, E_valid_i, E_isDIV_i, E_isFPU_i, E_hazard_i, E_stall_i, E_flush_i;
    logic div_start_o, div_done_i, fpu_start_o, fpu_done_i;
    logic [31:0] div_result_i, fpu_result_i, mc_result_o;
    logic mc_busy_o, mc_resultValid_o, timeout_o;
    logic [CNT_W-1:0] mc_stallCycles_o;

    exec_mc_scheduler #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CNT_W)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .E_valid_i        (E_valid_i),
        .E_isDIV_i        (E_isDIV_i),
        .E_isFPU_i        (E_isFPU_i),
        .E_hazard_i       (E_hazard_i),
        .E_stall_i        (E_stall_i),
        .E_flush_i        (E_flush_i),
        .div_start_o      (div_start_o),
        .div_done_i       (div_done_i),
        .div_result_i     (div_result_i),
        .fpu_start_o      (fpu_start_o),
        .fpu_done_i       (fpu_done_i),
        .fpu_result_i     (fpu_result_i),
        .mc_busy_o        (mc_busy_o),
        .mc_resultValid_o (mc_resultValid_o),
        .mc_result_o      (mc_result_o),
        .timeout_o        (timeout_o),
        .mc_stallCycles_o (mc_stallCycles_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: last captured result and sticky timeout
    logic [31:0] m_result;
    bit          m_timeout;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        E_valid_i = 0; E_isDIV_i = 0; E_isFPU_i = 0;
        E_hazard_i = 0; E_stall_i = 0; E_flush_i = 0;
        div_done_i = 0; fpu_done_i = 0;
        div_result_i = $urandom; fpu_result_i = $urandom;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_i = 1;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 0;
        m_result  = 32'h0;
        m_timeout = 0;
    endtask

    task automatic drive_done(input bit unit_div, input logic [31:0] v);
        if (unit_div) begin div_done_i = 1; div_result_i = v; end
        else          begin fpu_done_i = 1; fpu_result_i = v; end
    endtask

    // One instruction: hz hazard cycles, unit done after n cycles (0 = never),
    // flush fl cycles after start (-1 = none), st stall cycles while holding.
    task automatic run_op(input bit dv, input bit fp, input int hz, input int n,
                          input int fl, input int st, input logic [31:0] val);
        int s, vc, de, end_c, exp_busy;
        int sd, sf, first_start, busy_cnt, rv_cnt, first_rv, rv_busy;
        bit flushed, exp_to, instr, r, sel_div;
        logic [31:0] exp_res;
        logic [CNT_W-1:0] sc0;

        s = hz; flushed = (fl >= 0); sel_div = dv;
        vc = 0; de = 0;
        if (!flushed) begin
            exp_to   = !(n > 0 && n <= TO);
            vc       = exp_to ? TO + 1 : n + 1;
            exp_res  = exp_to ? 32'hFFFF_FFFF : val;
            exp_busy = vc;
            end_c    = s + vc + st + 1;
        end else begin
            exp_to   = !(n > fl && n <= TO);
            de       = exp_to ? TO + 1 : n + 1;
            exp_res  = m_result;
            exp_busy = fl + 1;
            end_c    = s + de;
        end
        sd = 0; sf = 0; first_start = -1; busy_cnt = 0;
        rv_cnt = 0; first_rv = -1; rv_busy = 0;
        sc0 = mc_stallCycles_o;

        for (int c = 0; c <= end_c + 1; c++) begin
            instr = flushed ? (c <= s + fl) : (c <= s + vc + st);
            E_valid_i  = instr;
            E_isDIV_i  = instr & dv;
            E_isFPU_i  = instr & fp;
            E_hazard_i = instr && (c < s);
            E_stall_i  = !flushed && (c >= s + vc) && (c < s + vc + st);
            E_flush_i  = flushed && (c == s + fl);
            if (flushed && c > s + fl && c < s + de) begin
                r = 1'($urandom_range(0, 1));
                E_valid_i = r; E_isDIV_i = r; E_hazard_i = 1;
                if (r) exp_busy++;
            end
            div_done_i = 0; fpu_done_i = 0;
            div_result_i = $urandom; fpu_result_i = $urandom;
            if (n > 0 && c == s + n)            drive_done(sel_div, val);
            else if (c == s)                    drive_done(sel_div, 32'hBAD0_0001);
            else if (n > 1 && c == s + 1)       drive_done(!sel_div, 32'hBAD0_0002);
            else if (!flushed && c == s + vc)   drive_done(sel_div, 32'hBAD0_0003);
            @(negedge clk_i);
            if (div_start_o) sd++;
            if (fpu_start_o) sf++;
            if ((div_start_o || fpu_start_o) && first_start < 0) first_start = c;
            if (mc_busy_o) busy_cnt++;
            if (mc_resultValid_o) begin
                rv_cnt++;
                if (first_rv < 0) first_rv = c;
                if (mc_busy_o) rv_busy++;
            end
            @(posedge clk_i); #1;
        end
        idle_inputs();

        check_eq("start_total", sd + sf, 1);
        check_eq("start_div", sd, dv);
        check_eq("start_cycle", first_start, s);
        check_eq("busy_cycles", busy_cnt, exp_busy);
        check_eq("stall_ctr", mc_stallCycles_o - sc0, exp_busy);
        if (!flushed) begin
            check_eq("valid_cycle", first_rv, s + vc);
            check_eq("valid_len", rv_cnt, st + 1);
            check_eq("busy_in_hold", rv_busy, 0);
            m_result = exp_res;
        end else begin
            check_eq("valid_flushed", rv_cnt, 0);
        end
        check_eq("result", mc_result_o, m_result);
        m_timeout = m_timeout | exp_to;
        check_eq("timeout", timeout_o, m_timeout);
    endtask

    initial begin
        logic [CNT_W-1:0] sc_base;
        int hz, n, fl, st;
        bit dv, fp;

        idle_inputs();
        reset_i = 1;
        do_reset();
        @(negedge clk_i);
        check_eq("rst_busy", mc_busy_o, 0);
        check_eq("rst_valid", mc_resultValid_o, 0);
        check_eq("rst_result", mc_result_o, 0);
        check_eq("rst_timeout", timeout_o, 0);
        check_eq("rst_stall", mc_stallCycles_o, 0);
        check_eq("rst_start", {div_start_o, fpu_start_o}, 0);
        @(posedge clk_i); #1;

        run_op(1, 0, 0, 33, -1, 0, 32'h0000_0007);
        run_op(0, 1, 3, 5, -1, 2, 32'h3F80_0000);
        run_op(1, 0, 0, 33, 5, 0, 32'h1234_5678);

        sc_base = mc_stallCycles_o;
        for (int i = 0; i < 3; i++) run_op(1, 1, 0, 4, -1, 0, 32'hA000_0000 + i);
        check_eq("stall_3ops", mc_stallCycles_o - sc_base, 15);

        for (int i = 0; i < 20; i++) begin
            dv = 1'($urandom_range(0, 1));
            fp = dv ? 1'($urandom_range(0, 1)) : 1'b1;
            hz = $urandom_range(0, 3);
            n  = $urandom_range(1, 40);
            fl = (n > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1;
            st = $urandom_range(0, 3);
            run_op(dv, fp, hz, n, fl, st, $urandom);
        end

        // Flush together with done: drain must time out
        run_op(1, 0, 0, 10, 10, 0, 32'h5555_5555);
        run_op(0, 1, 0, 6, -1, 0, 32'h0BAD_F00D);
        do_reset();

        // Hung FPU, then a normal op with timeout still sticky
        run_op(0, 1, 0, 0, -1, 1, 32'h0);
        run_op(1, 0, 1, 3, -1, 0, 32'h0000_0042);
        do_reset();
        check_eq("timeout_cleared", timeout_o, 0);

        // Reset mid-RUN with issue conditions and a done in the reset cycle
        E_valid_i = 1; E_isDIV_i = 1;
        @(posedge clk_i); #1;
        repeat (4) @(posedge clk_i);
        #1;
        reset_i = 1; div_done_i = 1; div_result_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        check_eq("rstrun_start", div_start_o, 0);
        check_eq("rstrun_busy", mc_busy_o, 0);
        @(posedge clk_i); #1;
        idle_inputs(); reset_i = 0;
        m_result = 32'h0; m_timeout = 0;
        @(negedge clk_i);
        check_eq("rstrun_valid", mc_resultValid_o, 0);
        check_eq("rstrun_result", mc_result_o, m_result);
        check_eq("rstrun_stall", mc_stallCycles_o, 0);
        @(posedge clk_i); #1;
        run_op(1, 0, 0, 2, -1, 0, 32'h0000_0099);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
